// File: rtl/pipe_pkg.sv
// Shared definitions for the EX/MEM elastic stage: control-bundle layout,
// the elastic buffer state encoding and a state-to-occupancy helper.
package pipe_pkg;

    // Bit offsets of the MEM/WB control fields inside the 7-bit ctrl bundle.
    localparam int DM_WRITE_BIT = 6;
    localparam int DM_CTRL_LSB  = 3;
    localparam int RU_SRC_LSB   = 1;
    localparam int RU_WRITE_BIT = 0;
    localparam int CTRL_BITS    = 7;

    // Control bundle as seen by MEM/WB, MSB first to match the offsets above.
    typedef struct packed {
        logic       dm_write;
        logic [2:0] dm_ctrl;
        logic [1:0] ru_data_src;
        logic       ru_write;
    } ex_me_ctrl_t;

    // Number of entries held by the elastic buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } elastic_state_t;

    // Occupancy is a direct image of the state: EMPTY=0, ONE=1, FULL=2.
    function automatic logic [1:0] state_occupancy(input elastic_state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_elastic_buf.sv
// Generic valid/ready pipeline register.
// Handshake: a transfer happens on a side exactly when valid && ready are both
// high at a rising edge; valid never depends on ready, and once valid is
// raised the data is held stable until the transfer completes.
// SKID=1: main + skid register, in_ready is a flop (no path from out_ready).
// SKID=0: main register only, in_ready = !out_valid || out_ready.
module pipe_elastic_buf
    import pipe_pkg::*;
#(
    parameter int W    = 8,
    parameter bit SKID = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output elastic_state_t dbg_state
);

    elastic_state_t state_q, state_d;
    logic [W-1:0]   main_q, main_d;
    logic [W-1:0]   skid_q, skid_d;
    logic           in_ready_q, in_ready_d;
    logic           in_fire;
    logic           out_fire;

    // The main register is always the head of the queue; the skid register
    // only ever holds the younger entry.
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign dbg_state = state_q;

    // in_ready is forced low while rst is asserted so nothing is accepted
    // in the reset cycle itself.
    assign in_ready = !rst && (SKID ? in_ready_q : (!out_valid || out_ready));

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Next state, storage moves and next in_ready.
    always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        skid_d     = skid_q;
        in_ready_d = 1'b1;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    if (SKID) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else begin
                        main_d = in_data;
                    end
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the output side can move.
                if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Flush squashes everything held; any output transfer this cycle has
        // already been sampled by MEM, and a same-cycle input is dropped.
        if (flush) begin
            state_d = EMPTY;
        end
        in_ready_d = (state_d != FULL);
    end

    // State and storage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: rtl/ex_me_elastic.sv
// EX/MEM stage register with valid/ready flow control, optional skid entry,
// flush and synchronous reset. Payload fields pass through untouched; the
// control bundle is zeroed whenever no instruction is presented so MEM/WB
// never see a stray dm_write or ru_write on a bubble.
module ex_me_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CTRL_W = 7,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc_inc,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_rs2,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc_inc,
    output logic [DATA_W-1:0] out_alu_res,
    output logic [DATA_W-1:0] out_rs2,
    output logic [RD_W-1:0]   out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    localparam int PAY_W = 3*DATA_W + RD_W + CTRL_W;

    logic [PAY_W-1:0]  pay_in;
    logic [PAY_W-1:0]  pay_out;
    logic [CTRL_W-1:0] ctrl_raw;
    elastic_state_t    buf_state;

    // Payload and ctrl travel as one vector so they are captured together.
    assign pay_in = {in_pc_inc, in_alu_res, in_rs2, in_rd, in_ctrl};

    pipe_elastic_buf #(
        .W    (PAY_W),
        .SKID (SKID)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pay_out),
        .dbg_state (buf_state)
    );

    assign {out_pc_inc, out_alu_res, out_rs2, out_rd, ctrl_raw} = pay_out;

    // Bubble mask: no control side effects leak out while invalid.
    assign out_ctrl  = ctrl_raw & {CTRL_W{out_valid}};
    assign occupancy = state_occupancy(buf_state);

endmodule

// File: tb/tb_ex_me_elastic.sv
// Directed bench for ex_me_elastic: one SKID=1 instance and one SKID=0
// instance share the same stimulus; each section checks the relevant one.
module tb_ex_me_elastic;

    localparam int DATA_W = 32;
    localparam int RD_W   = 5;
    localparam int CTRL_W = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_pc_inc;
    logic [DATA_W-1:0] in_alu_res;
    logic [DATA_W-1:0] in_rs2;
    logic [RD_W-1:0]   in_rd;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_ready;

    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_pc_inc;
    logic [DATA_W-1:0] out_alu_res;
    logic [DATA_W-1:0] out_rs2;
    logic [RD_W-1:0]   out_rd;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;

    logic              in_ready0;
    logic              out_valid0;
    logic [DATA_W-1:0] out_pc_inc0;
    logic [DATA_W-1:0] out_alu_res0;
    logic [DATA_W-1:0] out_rs20;
    logic [RD_W-1:0]   out_rd0;
    logic [CTRL_W-1:0] out_ctrl0;
    logic [1:0]        occupancy0;

    int n_assert = 0;
    int n_fail   = 0;

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    ex_me_elastic #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W), .SKID(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc_inc(in_pc_inc), .in_alu_res(in_alu_res), .in_rs2(in_rs2),
        .in_rd(in_rd), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc_inc(out_pc_inc), .out_alu_res(out_alu_res), .out_rs2(out_rs2),
        .out_rd(out_rd), .out_ctrl(out_ctrl), .occupancy(occupancy)
    );

    ex_me_elastic #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W), .SKID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_pc_inc(in_pc_inc), .in_alu_res(in_alu_res), .in_rs2(in_rs2),
        .in_rd(in_rd), .in_ctrl(in_ctrl),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_pc_inc(out_pc_inc0), .out_alu_res(out_alu_res0), .out_rs2(out_rs20),
        .out_rd(out_rd0), .out_ctrl(out_ctrl0), .occupancy(occupancy0)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] alu,
                         input logic [DATA_W-1:0] rs2, input logic [RD_W-1:0] rd,
                         input logic [CTRL_W-1:0] ctrl);
        in_valid   = v;
        in_pc_inc  = pc;
        in_alu_res = alu;
        in_rs2     = rs2;
        in_rd      = rd;
        in_ctrl    = ctrl;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0, '0, '0, '0, '0);

        // ---- Reset ----
        step();
        chk("rst_in_ready",  in_ready,    1'b0);
        chk("rst_out_valid", out_valid,   1'b0);
        chk("rst_occ",       occupancy,   2'd0);
        chk("rst_alu",       out_alu_res, 32'h0);
        chk("rst_ctrl",      out_ctrl,    7'h0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        // ---- Stream 4 back-to-back with out_ready=1 ----
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 4*i, 32'h10 + 4*i, 32'hBEEF_0000 + i, RD_W'(i + 1), CTRL_W'(i + 1));
            step();
            chk("stream_valid", out_valid,   1'b1);
            chk("stream_alu",   out_alu_res, 32'h10 + 4*i);
            chk("stream_pc",    out_pc_inc,  32'h100 + 4*i);
            chk("stream_rs2",   out_rs2,     32'hBEEF_0000 + i);
            chk("stream_rd",    out_rd,      i + 1);
            chk("stream_ctrl",  out_ctrl,    i + 1);
            chk("stream_occ",   occupancy,   2'd1);
            chk("stream_rdy",   in_ready,    1'b1);
        end
        in_valid = 1'b0;
        step();
        chk("drain_valid", out_valid,   1'b0);
        chk("drain_occ",   occupancy,   2'd0);
        chk("drain_ctrl",  out_ctrl,    7'h0);
        chk("drain_hold",  out_alu_res, 32'h1C);

        // ---- Stall fill: A0, A4 fill, A8 held off ----
        out_ready = 1'b0;
        drive(1'b1, 32'h200, 32'hA0, 32'h1, 5'd10, 7'h41);
        step();
        chk("fill1_occ", occupancy,   2'd1);
        chk("fill1_alu", out_alu_res, 32'hA0);
        chk("fill1_rdy", in_ready,    1'b1);
        drive(1'b1, 32'h204, 32'hA4, 32'h2, 5'd11, 7'h09);
        step();
        chk("fill2_occ",  occupancy,   2'd2);
        chk("fill2_rdy",  in_ready,    1'b0);
        chk("fill2_alu",  out_alu_res, 32'hA0);
        chk("fill2_ctrl", out_ctrl,    7'h41);
        drive(1'b1, 32'h208, 32'hA8, 32'h3, 5'd12, 7'h11);
        step();
        chk("hold_occ",  occupancy,   2'd2);
        chk("hold_alu",  out_alu_res, 32'hA0);
        chk("hold_rd",   out_rd,      5'd10);
        chk("hold_ctrl", out_ctrl,    7'h41);
        chk("hold_rdy",  in_ready,    1'b0);
        out_ready = 1'b1;
        step();
        chk("unst1_alu", out_alu_res, 32'hA4);
        chk("unst1_rd",  out_rd,      5'd11);
        chk("unst1_occ", occupancy,   2'd1);
        chk("unst1_rdy", in_ready,    1'b1);
        step();
        chk("unst2_alu", out_alu_res, 32'hA8);
        chk("unst2_occ", occupancy,   2'd1);
        in_valid = 1'b0;
        step();
        chk("unst3_valid", out_valid, 1'b0);

        // ---- Flush squash from FULL ----
        out_ready = 1'b0;
        drive(1'b1, 32'h300, 32'hB0, 32'h0, 5'd3, 7'h01);
        step();
        drive(1'b1, 32'h304, 32'hB4, 32'h0, 5'd4, 7'h01);
        step();
        chk("fl_full_occ", occupancy, 2'd2);
        drive(1'b1, 32'h308, 32'hB8, 32'h0, 5'd5, 7'h01);
        flush = 1'b1;
        step();
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_ctrl",  out_ctrl,  7'h0);
        chk("fl_occ",   occupancy, 2'd0);
        chk("fl_rdy",   in_ready,  1'b1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("fl_after_valid", out_valid, 1'b0);
        chk("fl_after_rd",    out_rd,    5'd3);

        // ---- Flush together with an output transfer ----
        drive(1'b1, 32'h400, 32'hC0, 32'h0, 5'd6, 7'h03);
        step();
        chk("flo_valid", out_valid, 1'b1);
        chk("flo_rd",    out_rd,    5'd6);
        in_valid = 1'b0; flush = 1'b1;
        step();
        chk("flo_gone",  out_valid, 1'b0);
        chk("flo_occ",   occupancy, 2'd0);
        flush = 1'b0;
        step();
        chk("flo_nodup", out_valid, 1'b0);

        // ---- Reset in the middle of a stall ----
        out_ready = 1'b0;
        drive(1'b1, 32'h500, 32'hD0, 32'h5, 5'd7, 7'h7F);
        step();
        drive(1'b1, 32'h504, 32'hD4, 32'h6, 5'd8, 7'h7F);
        step();
        chk("rs_full_occ", occupancy, 2'd2);
        in_valid = 1'b0; rst = 1'b1;
        #1;
        chk("rs_rdy_during", in_ready, 1'b0);
        step();
        chk("rs_valid", out_valid,   1'b0);
        chk("rs_occ",   occupancy,   2'd0);
        chk("rs_rd",    out_rd,      5'd0);
        chk("rs_alu",   out_alu_res, 32'h0);
        chk("rs_pc",    out_pc_inc,  32'h0);
        chk("rs_ctrl",  out_ctrl,    7'h0);
        rst = 1'b0;
        #1;
        chk("rs_rdy_after", in_ready, 1'b1);
        out_ready = 1'b1;
        step();
        chk("rs_no_replay", out_valid, 1'b0);

        // ---- SKID=0 instance ----
        out_ready = 1'b0;
        drive(1'b1, 32'h600, 32'hE0, 32'h9, 5'd9, 7'h05);
        step();
        chk("s0_valid", out_valid0,   1'b1);
        chk("s0_rd",    out_rd0,      5'd9);
        chk("s0_rdy0",  in_ready0,    1'b0);
        step();
        chk("s0_stall_occ", occupancy0,   2'd1);
        chk("s0_stall_alu", out_alu_res0, 32'hE0);
        out_ready = 1'b1;
        #1;
        chk("s0_rdy_comb", in_ready0, 1'b1);
        drive(1'b1, 32'h604, 32'hE4, 32'hA, 5'd13, 7'h06);
        step();
        chk("s0_rep1_alu", out_alu_res0, 32'hE4);
        chk("s0_rep1_occ", occupancy0,   2'd1);
        drive(1'b1, 32'h608, 32'hE8, 32'hB, 5'd14, 7'h07);
        step();
        chk("s0_rep2_alu",  out_alu_res0, 32'hE8);
        chk("s0_rep2_ctrl", out_ctrl0,    7'h07);
        in_valid = 1'b0;
        step();
        chk("s0_drain_valid", out_valid0, 1'b0);
        chk("s0_drain_occ",   occupancy0, 2'd0);
        chk("s0_drain_ctrl",  out_ctrl0,  7'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_me_elastic.md
Name: ex_me_elastic

Overview:
Parametrised EX/MEM pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, flush, and synchronous reset.
It carries PC+4, the ALU result, RS2, rd and the MEM/WB control bits (dm_write, dm_ctrl, ru_data_src, ru_write) from the execute stage to the memory stage.
It replaces the fixed, always-advancing stage register so the core can stall on slow data memory and squash wrong-path instructions without losing throughput.

Parameters:
DATA_W, 32, width of pc_inc, alu_res and rs2 fields
RD_W, 5, destination register index width
CTRL_W, 7, control bundle width: {dm_write[6], dm_ctrl[5:3], ru_data_src[2:1], ru_write[0]}
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready

Ports:
clk  in  1  stage clock; all state updates on posedge
rst  in  1  synchronous reset, active-high
flush  in  1  squash all held entries this cycle
in_valid  in  1  EX has an instruction
in_ready  out  1  stage can accept this cycle
in_pc_inc  in  DATA_W  PC+4
in_alu_res  in  DATA_W  ALU result / address
in_rs2  in  DATA_W  store data
in_rd  in  RD_W  destination register
in_ctrl  in  CTRL_W  MEM/WB control bundle
out_valid  out  1  MEM-side instruction present
out_ready  in  1  MEM accepts this cycle
out_pc_inc, out_alu_res, out_rs2  out  DATA_W  registered payload
out_rd  out  RD_W  registered rd
out_ctrl  out  CTRL_W  control bundle, forced to 0 when out_valid=0
occupancy  out  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Clock and reset: single clock clk, posedge only. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, occupancy=0, all out_* payload=0, out_ctrl=0, in_ready=0 during the rst cycle, in_ready=1 on the first cycle after.
- Transfer rules:
  - An input transfer happens when in_valid && in_ready.
  - An output transfer happens when out_valid && out_ready.
  - Payload and ctrl are captured together in the same cycle.
- Latency and throughput: 1 cycle from input transfer to out_valid. Sustained 1 instruction/cycle when out_ready stays high.
- SKID=1 FSM, states EMPTY, ONE, FULL:
  - EMPTY: input transfer -> ONE (main register loaded).
  - ONE: input without output -> FULL (skid register loaded). Output without input -> EMPTY. Both at once -> ONE (main loaded with new data).
  - FULL: in_ready=0. Output transfer -> ONE (skid moves to main, same edge).
  - in_ready = (state != FULL), driven from a register with no combinational path from out_ready.
- SKID=0: one register. in_ready = !out_valid || out_ready (combinational).
- Ordering: strict FIFO. The skid entry is never presented before the main entry.
- Bubble rule: whenever out_valid=0, out_ctrl=0, so MEM and WB see no dm_write or ru_write.
  - Payload holds its last value while invalid; no change is required.
- Stall: while out_valid && !out_ready, every out_* signal is held bit-stable.
- Flush:
  - On a cycle with flush=1, next state = EMPTY, out_valid=0 and occupancy=0 on the following cycle.
  - A simultaneous input transfer is discarded; flush wins.
  - An output transfer in the flush cycle still completes, since MEM already sampled it.
  - in_ready is unaffected by flush in that cycle.
- Reset precedence: rst overrides flush and any in-flight transfer.
  - rst mid-stall drops both entries; nothing is replayed.
- Occupancy tracks state: EMPTY=0, ONE=1, FULL=2.
- Widths: no arithmetic; all fields are passed through unmodified, with zero extension never applied.

Decomposition:
- Package pipe_pkg holds:
  - the CTRL field offset localparams (DM_WRITE_BIT=6, DM_CTRL_LSB=3, RU_SRC_LSB=1, RU_WRITE_BIT=0);
  - typedef ex_me_ctrl_t as a packed struct of the 4 control fields;
  - the FSM state enum elastic_state_t {EMPTY, ONE, FULL}.
- Sub-module pipe_elastic_buf: a generic valid/ready register with params W and SKID, holding the FSM and storage.
- ex_me_elastic:
  - concatenates the fields into one payload vector of width 3*DATA_W+RD_W+CTRL_W;
  - instantiates pipe_elastic_buf;
  - splits the outputs back into fields and applies the ctrl bubble mask.

Test Plan:
- Reset then stream: rst 2 cycles, then 4 back-to-back inputs with alu_res=0x10,0x14,0x18,0x1C and out_ready=1 -> out_valid from cycle 1, outputs 0x10..0x1C on consecutive cycles, occupancy stays 1.
- Stall fill: with out_ready=0, send alu_res=0xA0, then 0xA4 -> occupancy=2 and in_ready=0. A third input 0xA8 is held off. Raise out_ready -> outputs in order 0xA0, 0xA4, 0xA8.
- Flush squash: state FULL (rd=3, rd=4, ctrl ru_write=1), pulse flush with in_valid=1 (rd=5) -> next cycle out_valid=0, out_ctrl=0, occupancy=0, and rd=5 never appears.
- Flush with output transfer: ONE, out_ready=1, flush=1 in the same cycle -> the entry counts as consumed; no duplicate on the next cycle.
- Reset mid-stall: FULL with out_ready=0, assert rst for 1 cycle -> all outputs 0, in_ready=1 the next cycle, and neither old entry reappears.
- SKID=0 variant: out_valid=1, out_ready=0 -> in_ready=0 in the same cycle. out_ready=1 with a new input -> replaced in 1 cycle, throughput 1/cycle.
